// File: rtl/fetch_stage.sv
// Instruction-fetch stage.
// Owns the PC and keeps at most one fetch outstanding on a req/gnt/rvalid
// instruction-memory port. Returned words go into a DEPTH-entry buffer whose
// head is presented to decode as registered {instr, pc, pc+4} under
// valid/ready. A taken branch/jump from execute (b_sel) redirects the PC,
// flushes the buffer and discards any response still in flight.
module fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        b_sel,
  input  logic [31:0] b_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fb_entry_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   fetch_pc;   // address of the fetch currently in flight
  logic          req_q;

  fb_entry_t     mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [CW-1:0] count, count_mid, count_nxt;

  logic          out_valid;
  logic [31:0]   out_instr, out_pc, out_pc4;

  logic          push, pop, head_valid_nxt;
  fb_entry_t     head_nxt;

  // A redirect kills both the in-flight response and any consumption this cycle.
  assign push = (state == S_WAIT) && imem_rvalid && !b_sel;
  assign pop  = out_valid && id_ready && !b_sel;

  assign count_mid      = count - CW'(pop);
  assign count_nxt      = count_mid + CW'(push);
  assign rd_ptr_nxt     = rd_ptr + AW'(pop);
  assign head_valid_nxt = !b_sel && (count_nxt != '0);

  // Next head: oldest stored entry that survives the pop, else the word arriving now.
  always_comb begin
    head_nxt = '{instr: imem_rdata, pc: fetch_pc};
    if (count_mid != '0) head_nxt = mem[rd_ptr_nxt];
  end

  // Fetch FSM: PC, request and state; redirect overrides everything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_VEC;
      fetch_pc <= '0;
      req_q    <= 1'b0;
    end else if (b_sel) begin
      pc <= b_target & ~32'h3;
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
        S_REQ: begin
          // a request granted in the redirect cycle still gets a response
          state <= imem_gnt ? S_DROP : S_REQ;
          req_q <= !imem_gnt;
        end
        S_WAIT: begin
          state <= imem_rvalid ? S_REQ : S_DROP;
          req_q <= imem_rvalid;
        end
        default: begin
          state <= imem_rvalid ? S_REQ : S_DROP;
          req_q <= imem_rvalid;
        end
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          if (count < DEPTH_C) begin
            state <= S_REQ;
            req_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (imem_gnt) begin
            state    <= S_WAIT;
            req_q    <= 1'b0;
            fetch_pc <= pc;
            pc       <= pc + 32'd4;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            // only request again if the buffer can hold the next word
            if (count_nxt < DEPTH_C) begin
              state <= S_REQ;
              req_q <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          if (imem_rvalid) begin
            state <= S_REQ;
            req_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Buffer pointers and occupancy; flushed by reset or redirect.
  always_ff @(posedge clk) begin
    if (rst || b_sel) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count  <= count_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
    end
  end

  // Buffer storage; no reset needed, occupancy qualifies every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: imem_rdata, pc: fetch_pc};
  end

  // Registered decode-facing head; holds while decode stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      out_pc4   <= '0;
    end else begin
      out_valid <= head_valid_nxt;
      if (head_valid_nxt) begin
        out_instr <= head_nxt.instr;
        out_pc    <= head_nxt.pc;
        out_pc4   <= head_nxt.pc + 32'd4;
      end
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc;
  assign id_valid  = out_valid;
  assign id_instr  = out_instr;
  assign id_pc     = out_pc;
  assign id_pc4    = out_pc4;

endmodule
